onehot_decoder_seq: RTL

ONEHOT_DECODER_SEQ -- requirements
Module: onehot_decoder_seq

---
 rtl/onehot_dec_pkg.sv | 17 +
 rtl/onehot_dec_core.sv | 44 ++++
 rtl/onehot_decoder_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/onehot_dec_pkg.sv
// onehot_dec_pkg
//   Shared types and constants for the sequential one-hot decoder.
//   - state_e     : controller states (IDLE / HOLD / SCAN)
//   - MODE_DECODE : mode input value selecting decode of sel
//   - MODE_SCAN   : mode input value selecting the walking-one scan
package onehot_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    SCAN = 2'd2
  } state_e;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/onehot_dec_core.sv
// onehot_dec_core
//   Purely combinational index to one-hot converter with range check.
//   Codes at or above NUM_OUT produce an all-zero vector and raise err,
//   so the output is always fully defined.
//   Ports:
//     idx    in  [SEL_W-1:0]     code to convert
//     onehot out [2**SEL_W-1:0]  1<<idx when idx < NUM_OUT, else 0
//     err    out                 idx >= NUM_OUT
module onehot_dec_core
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 6
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [2**SEL_W-1:0]   onehot,
  output logic                  err
);

  localparam int OUT_W = 2**SEL_W;

  // One comparator per output bit; bits at or above NUM_OUT are tied low
  // so an out-of-range code can never light a bit.
  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_bit
      if (gi < NUM_OUT) begin : g_legal
        assign onehot[gi] = (idx == SEL_W'(gi));
      end else begin : g_illegal
        assign onehot[gi] = 1'b0;
      end
    end
  endgenerate

  // With every code legal the range check collapses to a constant.
  generate
    if (NUM_OUT >= OUT_W) begin : g_full_range
      assign err = 1'b0;
    end else begin : g_partial_range
      assign err = ({1'b0, idx} >= (SEL_W+1)'(NUM_OUT));
    end
  endgenerate

endmodule

// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq
//   Registered one-hot decoder with valid/ready handshakes on both sides
//   and an autonomous walking-one SCAN mode.
//   Ports:
//     clk        in   single clock, rising edge
//     rst        in   synchronous active-high reset
//     mode       in   0 = decode sel, 1 = scan through legal codes
//     in_valid   in   sel is valid
//     in_ready   out  block accepts sel this cycle (combinational)
//     sel        in   [SEL_W-1:0] code to decode
//     out_valid  out  res/err valid (registered)
//     out_ready  in   consumer accepts res
//     res        out  [2**SEL_W-1:0] registered one-hot result
//     err        out  registered code was >= NUM_OUT
module onehot_decoder_seq
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int NUM_OUT = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   res,
  output logic                  err
);

  localparam int                OUT_W    = 2**SEL_W;
  localparam logic [SEL_W-1:0]  LAST_IDX = SEL_W'(NUM_OUT - 1);

  // Refuse to build with an impossible code count.
  generate
    if (NUM_OUT < 1 || NUM_OUT > OUT_W) begin : g_bad_num_out
      $error("onehot_decoder_seq: NUM_OUT must be in 1..2**SEL_W");
    end
  endgenerate

  state_e              state_reg, state_next;
  logic [SEL_W-1:0]    idx_reg, idx_next;
  logic [OUT_W-1:0]    res_reg, res_next;
  logic                err_reg, err_next;
  logic                out_valid_reg, out_valid_next;

  logic                in_fire;
  logic                out_fire;
  logic [SEL_W-1:0]    scan_idx;
  logic [OUT_W-1:0]    sel_onehot, scan_onehot;
  logic                sel_err, scan_err;

  // A new sel is taken when empty, or in HOLD when the current result
  // leaves in the same cycle (back-to-back decode). SCAN never accepts.
  assign in_ready = (state_reg == IDLE) |
                    ((state_reg == HOLD) & out_ready & (mode == MODE_DECODE));

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_reg & out_ready;

  // Next scan position: entering SCAN starts at 0, otherwise step with
  // wrap at the last legal code.
  assign scan_idx = (state_reg != SCAN) ? '0 :
                    (idx_reg == LAST_IDX) ? '0 : (idx_reg + SEL_W'(1));

  // One converter for the incoming code, one for the scan position.
  onehot_dec_core #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_sel_core (
    .idx     (sel),
    .onehot  (sel_onehot),
    .err     (sel_err)
  );

  onehot_dec_core #(
    .SEL_W   (SEL_W),
    .NUM_OUT (NUM_OUT)
  ) u_scan_core (
    .idx     (scan_idx),
    .onehot  (scan_onehot),
    .err     (scan_err)
  );

  // State and output registers; every output except in_ready is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      res_reg       <= '0;
      err_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      res_reg       <= res_next;
      err_reg       <= err_next;
      out_valid_reg <= out_valid_next;
    end
  end

  // Next-state logic. mode is only looked at in IDLE and SCAN; a pending
  // SCAN value is always delivered before dropping back to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_fire) begin
          state_next = HOLD;
        end else if (mode == MODE_SCAN) begin
          state_next = SCAN;
        end
      end
      HOLD: begin
        if (out_fire && !in_fire) begin
          state_next = IDLE;
        end
      end
      SCAN: begin
        if (out_fire && (mode == MODE_DECODE)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs and scan index.
  always_comb begin
    idx_next       = idx_reg;
    res_next       = res_reg;
    err_next       = err_reg;
    out_valid_next = out_valid_reg;
    case (state_reg)
      IDLE: begin
        if (in_fire) begin
          // Decode wins over scan when both are possible.
          res_next       = sel_onehot;
          err_next       = sel_err;
          out_valid_next = 1'b1;
        end else if (mode == MODE_SCAN) begin
          idx_next       = scan_idx;
          res_next       = scan_onehot;
          err_next       = scan_err;
          out_valid_next = 1'b1;
        end
      end
      HOLD: begin
        if (in_fire) begin
          // in_fire here implies out_fire: replace the leaving result.
          res_next       = sel_onehot;
          err_next       = sel_err;
          out_valid_next = 1'b1;
        end else if (out_fire) begin
          out_valid_next = 1'b0;
        end
      end
      SCAN: begin
        if (out_fire) begin
          if (mode == MODE_DECODE) begin
            out_valid_next = 1'b0;
          end else begin
            idx_next = scan_idx;
            res_next = scan_onehot;
            err_next = scan_err;
          end
        end
      end
      default: begin
        out_valid_next = 1'b0;
      end
    endcase
  end

  assign out_valid = out_valid_reg;
  assign res       = res_reg;
  assign err       = err_reg;

endmodule
